// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 target emulator: a qualified trig pulse yields an echo pulse of programmed width.
// Echo rises BURST_CYCLES+1 cycles after the synchronized trig fall; no backpressure, trig outside IDLE/TRIG_HI is ignored.
module ultrasonic_echo_responder #(
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_CYCLES    = 10000,
  parameter int MAX_ECHO_CYCLES = 1900000,
  parameter int HOLDOFF_CYCLES  = 500000,
  parameter int WIDTH_W         = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               trig,
  input  logic [WIDTH_W-1:0] echo_width,
  output logic               echo,
  output logic               busy,
  output logic               short_trig_err,
  output logic [15:0]        pulse_count
);

  localparam int CNT_MAX_A = (MIN_TRIG_CYCLES > BURST_CYCLES) ? MIN_TRIG_CYCLES : BURST_CYCLES;
  localparam int CNT_MAX_B = (MAX_ECHO_CYCLES > HOLDOFF_CYCLES) ? MAX_ECHO_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MIN_C      = CNT_W'(MIN_TRIG_CYCLES);
  localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] MAX_W      = WIDTH_W'(MAX_ECHO_CYCLES);
  localparam logic [WIDTH_W-1:0] W_ONE      = WIDTH_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]   w_last, w_last_nx;
  logic               err_nx;
  logic               pc_inc;
  logic               trig_m, trig_s, trig_q;
  logic               trig_rise;
  logic [WIDTH_W-1:0] width_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_q <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_q;

  // Zero and out-of-range widths both fall back to the no-object echo.
  assign width_sel = ((echo_width == '0) || (echo_width > MAX_W)) ? MAX_W : echo_width;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    w_last_nx = w_last;
    err_nx    = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise && enable) begin
          state_nx = TRIG_HI;
          cnt_nx   = CNT_ONE;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (cnt < MIN_C) cnt_nx = cnt + CNT_ONE;
        end else if (cnt >= MIN_C) begin
          state_nx  = BURST;
          cnt_nx    = '0;
          w_last_nx = CNT_W'(width_sel - W_ONE);
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
          err_nx   = 1'b1;
        end
      end
      BURST: begin
        if (cnt == BURST_LAST) begin
          state_nx = ECHO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ECHO: begin
        if (cnt == w_last) begin
          state_nx = HOLDOFF;
          cnt_nx   = '0;
          pc_inc   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // echo is registered from the next state so it is high exactly while the FSM sits in ECHO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      w_last         <= '0;
      echo           <= 1'b0;
      short_trig_err <= 1'b0;
      pulse_count    <= 16'd0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      w_last         <= w_last_nx;
      echo           <= (state_nx == ECHO);
      short_trig_err <= err_nx;
      if (pc_inc) pulse_count <= pulse_count + 16'd1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
- Emulates the target side of an HC-SR04-style ultrasonic ranging sensor.
- Accepts a trigger pulse and returns an echo pulse whose width equals a programmed cycle count.
- Lets the proximity-sensor driver be exercised on-board (loopback across GPIO) or in simulation without a physical sensor.
- Sits beside the driver, clocked from CLOCK_50.

Parameters:
- MIN_TRIG_CYCLES, 500, minimum synchronized trig high time for a valid trigger (10 us at 50 MHz).
- BURST_CYCLES, 10000, delay from accepted trig fall to echo rise (emulated 8-cycle 40 kHz burst, 200 us).
- MAX_ECHO_CYCLES, 1900000, no-object echo width (38 ms); also the clamp for echo_width.
- HOLDOFF_CYCLES, 500000, dead time after echo fall before the next trigger is accepted (10 ms).
- WIDTH_W, 22, width of echo_width.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits acceptance of new triggers
- trig  in  1  trigger from driver; asynchronous, 2-FF synchronized internally
- echo_width  in  WIDTH_W  echo high time in clk cycles; sampled on trigger acceptance
- echo  out  1  echo pulse to driver, registered
- busy  out  1  high in any state other than IDLE
- short_trig_err  out  1  one-cycle pulse when a trig high time is below MIN_TRIG_CYCLES
- pulse_count  out  16  count of echo pulses emitted; wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - echo=0, busy=0, short_trig_err=0, pulse_count=0.
  - Synchronizer flops=0, state=IDLE, all counters=0.
  - Applies immediately, including mid-echo; echo drops without waiting for a clock.
- trig_s = trig after 2 FFs; edges are detected on trig_s against its previous value.
- IDLE:
  - On rising edge of trig_s with enable=1 -> TRIG_HI, trig counter=1.
  - If trig_s is already high on entry to IDLE, it is ignored; a fresh rising edge is required.
  - enable=0 blocks only acceptance in IDLE.
- TRIG_HI:
  - While trig_s=1, the trig counter increments, saturating at MIN_TRIG_CYCLES.
  - On trig_s fall with counter >= MIN_TRIG_CYCLES:
    - Latch W = (echo_width==0 || echo_width>MAX_ECHO_CYCLES) ? MAX_ECHO_CYCLES : echo_width.
    - Go to BURST with burst counter=0.
  - On trig_s fall with counter < MIN_TRIG_CYCLES: short_trig_err=1 for exactly one cycle, go to IDLE, echo is not produced.
  - Deasserting enable during TRIG_HI does not abort.
- BURST:
  - echo=0; counts BURST_CYCLES cycles, then ECHO.
  - echo rises exactly BURST_CYCLES+1 clk cycles after the cycle in which the trig_s fall is detected.
- ECHO:
  - echo=1 for exactly W consecutive cycles.
  - On the last cycle: pulse_count increments, echo falls on the next edge, go to HOLDOFF.
- HOLDOFF:
  - echo=0 for HOLDOFF_CYCLES cycles, then IDLE.
- Trig activity in BURST, ECHO and HOLDOFF is ignored: no error, no restart, no effect on W.
- echo_width changes after latching have no effect on the pulse in flight.
- busy=1 from entry to TRIG_HI through the last HOLDOFF cycle.
- Counters are sized for MAX_ECHO_CYCLES and HOLDOFF_CYCLES; no overflow inside any state.
- All parameters must be >=1; a bench may override them to small values.

Test Plan:
- Params MIN=5, BURST=4, MAX=50, HOLD=6; echo_width=20; trig high 8 cycles -> echo rises 5 cycles after the trig_s fall, stays high exactly 20 cycles, pulse_count=1, busy drops 6 cycles after echo fall.
- Same params, trig high 3 cycles -> one-cycle short_trig_err, echo stays 0, pulse_count unchanged, busy returns to 0.
- echo_width=0, then echo_width=200 (>MAX=50) on separate triggers -> each echo is exactly 50 cycles wide; pulse_count increments by 2.
- Second trig pulse (8 cycles) during ECHO and during HOLDOFF -> ignored; only one echo is emitted. A trig held high across the HOLDOFF->IDLE transition is ignored until it falls and rises again.
- enable=0 with a valid trig -> no response. enable dropped mid-TRIG_HI -> the echo still completes.
- rst_n asserted 10 cycles into ECHO -> echo=0 immediately (asynchronous), pulse_count=0, busy=0. After release, a valid trig produces a correct echo.
